conv_result_streamer: RTL and testbench
=======================================

// Module: conv_result_streamer
// PURPOSE
//  Downstream stage of the 3x3 systolic convolution core. It waits a fixed number of
//  cycles after a start pulse, then captures the four 2x2 results o00..o11.
//  It applies optional ReLU and computes the 2x2 max-pool of the results.
//  It streams five bytes out over valid/ready: o00, o01, o10, o11, pool_max.
// PARAMETERS
//  DATA_W         8   width of each result byte
//  CAPTURE_CYCLE  17  clock edges from the start-sampling edge to the capture edge (min 2, max 255)
//  RELU_EN        1   1: negative results (two's complement, MSB=1) are forced to 0 before output and pooling
// PORTS
//  clk_in    in   1       single clock, rising edge
//  rst       in   1       asynchronous, active-low reset
//  start     in   1       1-cycle pulse, aligned with the core's reset release; ignored unless IDLE
//  o00       in   DATA_W  core result (0,0)
//  o01       in   DATA_W  core result (0,1)
//  o10       in   DATA_W  core result (1,0)
//  o11       in   DATA_W  core result (1,1)
//  m_data    out  DATA_W  stream data
//  m_valid   out  1       stream valid
//  m_ready   in   1       stream ready from consumer
//  m_last    out  1       high with beat 4 (pool_max)
//  m_index   out  3       beat number 0..4
//  busy      out  1       high in WAIT and SEND
//  done      out  1       1-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, cnt=0, capture regs=0.
//    All outputs are 0: m_data, m_valid, m_last, m_index, busy, done.
//  - FSM states: IDLE, WAIT, SEND, DONE (2-bit encoding).
//  - IDLE: if start=1 at edge E0, go to WAIT with cnt=1.
//  - WAIT: cnt increments by 1 each edge.
//    At the edge where cnt==CAPTURE_CYCLE (edge E0+CAPTURE_CYCLE):
//    capture the four inputs after ReLU, register pool_max, set beat=0, go to SEND.
//  - SEND: m_valid=1; m_data = beat 0..4 = r00, r01, r10, r11, pool_max.
//    A beat is transferred on an edge with m_valid&&m_ready; beat then increments.
//    On transfer of beat 4 (m_last=1), go to DONE.
//    While m_valid&&!m_ready, m_data, m_index and m_last hold stable.
//    m_valid never drops before the transfer.
//  - Latency: first m_valid is seen in the cycle after edge E0+CAPTURE_CYCLE.
//    With m_ready tied high, the 5 beats occupy 5 consecutive cycles.
//  - DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
//  - start while busy or in DONE: ignored; no restart, no error.
//  - Inputs are sampled only at the capture edge. Changes at any other time have no effect.
//  - ReLU: r = (RELU_EN && x[DATA_W-1]) ? 0 : x.
//  - pool_max: signed (two's complement) max of r00..r11; ties resolve to the equal value.
//    If RELU_EN=1 all values are >= 0.
//  - No arithmetic widening; all values stay DATA_W.
//  - cnt is 8 bits and never wraps, because CAPTURE_CYCLE <= 255.
//  - rst asserted mid-WAIT or mid-SEND: immediate return to reset values.
//    The partially sent frame is abandoned; the consumer sees m_valid fall asynchronously.
// STRUCTURE
//  - Shared package/header holds:
//    state encodings ST_IDLE=0, ST_WAIT=1, ST_SEND=2, ST_DONE=3;
//    NUM_BEATS=5; LAST_BEAT=4.
//  - One sub-module: signed_max4 (combinational, DATA_W parameter).
//    It takes the four ReLU'd values and returns pool_max; its result is registered at capture.
//  - Top level contains the FSM, cnt, beat counter, capture registers and output mux.
// TESTING
//  1 Reset: hold rst=0 with random inputs.
//    -> all outputs 0. Release rst -> outputs stay 0 with no start.
//  2 Nominal: start at E0; o00=5, o01=12, o10=3, o11=9; m_ready=1.
//    -> m_valid rises after E0+17; beats 5, 12, 3, 9, 12 with m_index 0..4; m_last on 12.
//    -> done pulses for 1 cycle.
//  3 ReLU: o00=8'hF0, o01=8'h81, o10=2, o11=0; RELU_EN=1.
//    -> beats 0, 0, 2, 0, pool 2.
//    With RELU_EN=0 -> beats F0, 81, 02, 00, pool 02 (signed max).
//  4 Backpressure: m_ready toggles 0,0,1,0,1...
//    -> each beat held stable until accepted; no beat lost or duplicated; order preserved.
//  5 Ignored start: pulse start during WAIT and during SEND.
//    -> capture time and frame unchanged.
//    Start in IDLE after done -> a new frame starts.
//  6 Mid-op reset: assert rst at beat 2 of SEND.
//    -> m_valid=0 immediately. A new start after release produces a complete 5-beat frame.

Source files
------------

// File: rtl/conv_result_streamer_pkg.sv
// rtl/conv_result_streamer_pkg.sv - shared encodings and frame constants for the result streamer
package conv_result_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int NUM_BEATS = 5;
    localparam int LAST_BEAT = NUM_BEATS - 1;
    localparam int CNT_W     = 8;
    localparam int BEAT_W    = 3;

    function automatic logic is_last_beat(input logic [BEAT_W-1:0] beat);
        return beat == BEAT_W'(LAST_BEAT);
    endfunction

endpackage

// File: rtl/conv_result_streamer_signed_max4.sv
// rtl/conv_result_streamer_signed_max4.sv - combinational two's complement max of four values
module signed_max4 #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] max_val
);

    logic [DATA_W-1:0] max_ab;
    logic [DATA_W-1:0] max_cd;

    // Two-level tree; ties keep the left operand, which is the same value anyway.
    always_comb begin
        max_ab  = ($signed(a) >= $signed(b)) ? a : b;
        max_cd  = ($signed(c) >= $signed(d)) ? c : d;
        max_val = ($signed(max_ab) >= $signed(max_cd)) ? max_ab : max_cd;
    end

endmodule

// File: rtl/conv_result_streamer.sv
// rtl/conv_result_streamer.sv - timed capture of 2x2 conv results, ReLU, max-pool and 5-beat stream
module conv_result_streamer
    import conv_result_streamer_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int CAPTURE_CYCLE = 17,
    parameter bit RELU_EN       = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] o00,
    input  logic [DATA_W-1:0] o01,
    input  logic [DATA_W-1:0] o10,
    input  logic [DATA_W-1:0] o11,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [2:0]        m_index,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(CAPTURE_CYCLE);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BEAT_W-1:0]   beat;
    logic [DATA_W-1:0]   r00, r01, r10, r11, pool_q;
    logic [DATA_W-1:0]   r00_n, r01_n, r10_n, r11_n, pool_n;
    logic [BEAT_W-1:0]   beat_nxt;
    logic [DATA_W-1:0]   data_nxt;

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
        return (RELU_EN && x[DATA_W-1]) ? '0 : x;
    endfunction

    always_comb begin
        r00_n = relu(o00);
        r01_n = relu(o01);
        r10_n = relu(o10);
        r11_n = relu(o11);
    end

    signed_max4 #(.DATA_W(DATA_W)) u_max4 (
        .a       (r00_n),
        .b       (r01_n),
        .c       (r10_n),
        .d       (r11_n),
        .max_val (pool_n)
    );

    // Beat 0 is loaded at capture, so the mux only has to cover beats 1..4.
    always_comb begin
        beat_nxt = beat + 3'd1;
        case (beat_nxt)
            3'd1:    data_nxt = r01;
            3'd2:    data_nxt = r10;
            3'd3:    data_nxt = r11;
            default: data_nxt = pool_q;
        endcase
    end

    assign m_index = beat;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            beat    <= '0;
            r00     <= '0;
            r01     <= '0;
            r10     <= '0;
            r11     <= '0;
            pool_q  <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_W'(1);
                        busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == CAP_CNT) begin
                        r00     <= r00_n;
                        r01     <= r01_n;
                        r10     <= r10_n;
                        r11     <= r11_n;
                        pool_q  <= pool_n;
                        beat    <= '0;
                        m_data  <= r00_n;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        state   <= ST_SEND;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (m_ready) begin
                        if (is_last_beat(beat)) begin
                            state   <= ST_DONE;
                            beat    <= '0;
                            m_data  <= '0;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            beat   <= beat_nxt;
                            m_data <= data_nxt;
                            m_last <= is_last_beat(beat_nxt);
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_result_streamer.sv
// tb/tb_conv_result_streamer.sv - scoreboard bench for conv_result_streamer, ReLU on and off
module tb_conv_result_streamer;

    localparam int CAP = 17;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] o00 = '0, o01 = '0, o10 = '0, o11 = '0;

    logic [7:0] m_data_a, m_data_b;
    logic       m_valid_a, m_valid_b, m_last_a, m_last_b;
    logic [2:0] m_index_a, m_index_b;
    logic       busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int errors = 0;

    beat_t q_a[$];
    beat_t q_b[$];
    logic       stall[2];
    logic [7:0] sd[2];
    logic [2:0] si[2];
    logic       sl[2];
    logic       done_exp[2];

    logic bp_pat[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk_in = ~clk_in;

    conv_result_streamer #(.DATA_W(8), .CAPTURE_CYCLE(CAP), .RELU_EN(1'b1)) dut_a (
        .clk_in(clk_in), .rst(rst), .start(start),
        .o00(o00), .o01(o01), .o10(o10), .o11(o11),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_last(m_last_a),
        .m_index(m_index_a), .busy(busy_a), .done(done_a)
    );

    conv_result_streamer #(.DATA_W(8), .CAPTURE_CYCLE(CAP), .RELU_EN(1'b0)) dut_b (
        .clk_in(clk_in), .rst(rst), .start(start),
        .o00(o00), .o01(o01), .o10(o10), .o11(o11),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_last(m_last_b),
        .m_index(m_index_b), .busy(busy_b), .done(done_b)
    );

    task automatic mon(input int id, input logic v, input logic l, input logic [7:0] d,
                       input logic [2:0] ix, input logic dn);
        beat_t e;
        if (!rst) begin
            if (id == 0) q_a.delete(); else q_b.delete();
            stall[id]    = 1'b0;
            done_exp[id] = 1'b0;
            return;
        end
        checks++;
        if (dn !== done_exp[id]) begin
            errors++;
            $display("FAIL done_pulse[%0d]: got %b expected %b", id, dn, done_exp[id]);
        end
        if (stall[id]) begin
            checks++;
            if (v !== 1'b1 || d !== sd[id] || ix !== si[id] || l !== sl[id]) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got v=%b d=%h i=%0d l=%b expected v=1 d=%h i=%0d l=%b",
                         id, v, d, ix, l, sd[id], si[id], sl[id]);
            end
        end
        if (v === 1'b1 && m_ready === 1'b1) begin
            checks++;
            if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_beat[%0d]: got d=%h i=%0d expected no beat", id, d, ix);
            end else begin
                e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                if (d !== e.data || ix !== e.idx || l !== e.last) begin
                    errors++;
                    $display("FAIL beat[%0d]: got d=%h i=%0d l=%b expected d=%h i=%0d l=%b",
                             id, d, ix, l, e.data, e.idx, e.last);
                end
            end
        end
        done_exp[id] = v && m_ready && l;
        stall[id]    = v && !m_ready;
        sd[id] = d;
        si[id] = ix;
        sl[id] = l;
    endtask

    always @(negedge clk_in) begin
        mon(0, m_valid_a, m_last_a, m_data_a, m_index_a, done_a);
        mon(1, m_valid_b, m_last_b, m_data_b, m_index_b, done_b);
    end

    task automatic check(input string name, input logic ok, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_zero(input string name);
        logic [29:0] all;
        all = {m_data_a, m_valid_a, m_last_a, m_index_a, busy_a, done_a,
               m_data_b, m_valid_b, m_last_b, m_index_b, busy_b, done_b};
        check(name, all == '0, 64'(all), 64'd0);
    endtask

    task automatic rand_inputs();
        o00 = 8'($urandom);
        o01 = 8'($urandom);
        o10 = 8'($urandom);
        o11 = 8'($urandom);
    endtask

    task automatic run_frame(input logic [7:0] v00, input logic [7:0] v01, input logic [7:0] v10,
                             input logic [7:0] v11, input logic [39:0] e_relu, input logic [39:0] e_raw,
                             input bit bp, input bit spur, input int abort_at);
        beat_t b;
        bit    fin;
        for (int i = 0; i < 5; i++) begin
            b.idx  = 3'(i);
            b.last = (i == 4);
            b.data = e_relu[39-8*i -: 8];
            q_a.push_back(b);
            b.data = e_raw[39-8*i -: 8];
            q_b.push_back(b);
        end
        start = 1'b1;
        rand_inputs();
        @(posedge clk_in); #1;
        for (int k = 1; k < CAP; k++) begin
            start = spur && (k == 5);
            rand_inputs();
            check("wait_phase", !m_valid_a && !m_valid_b && busy_a && busy_b,
                  64'({m_valid_a, m_valid_b, busy_a, busy_b}), 64'b0011);
            @(posedge clk_in); #1;
        end
        start = 1'b0;
        o00 = v00; o01 = v01; o10 = v10; o11 = v11;
        check("pre_capture", !m_valid_a && !m_valid_b, 64'({m_valid_a, m_valid_b}), 64'b00);
        @(posedge clk_in); #1;
        check("first_valid", m_valid_a && m_valid_b, 64'({m_valid_a, m_valid_b}), 64'b11);
        rand_inputs();
        fin = 1'b0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            m_ready = bp ? bp_pat[cyc % 5] : 1'b1;
            start   = spur && (cyc == 1);
            @(posedge clk_in); #1;
            if (abort_at >= 0 && m_valid_a && m_index_a == 3'(abort_at)) begin
                rst = 1'b0;
                #1;
                check_zero("async_reset");
                start   = 1'b0;
                m_ready = 1'b1;
                repeat (2) @(posedge clk_in);
                #1 rst = 1'b1;
                return;
            end
            if (done_a) fin = 1'b1;
        end
        check("frame_timeout", fin, 64'(fin), 64'd1);
        start   = 1'b0;
        m_ready = 1'b1;
        @(posedge clk_in); #1;
        check("back_to_idle", !busy_a && !busy_b && !done_a && !done_b && !m_valid_a && !m_valid_b,
              64'({busy_a, busy_b, done_a, done_b, m_valid_a, m_valid_b}), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            stall[i] = 1'b0; done_exp[i] = 1'b0; sd[i] = '0; si[i] = '0; sl[i] = 1'b0;
        end
        // Reset held with random activity on every input
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            start   = 1'($urandom);
            m_ready = 1'($urandom);
            @(posedge clk_in); #1;
            check_zero("reset_hold");
        end
        start   = 1'b0;
        m_ready = 1'b1;
        rst     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in); #1;
            check_zero("idle_no_start");
        end

        run_frame(8'd5, 8'd12, 8'd3, 8'd9, 40'h05_0C_03_09_0C, 40'h05_0C_03_09_0C, 1'b0, 1'b0, -1);
        run_frame(8'hF0, 8'h81, 8'h02, 8'h00, 40'h00_00_02_00_02, 40'hF0_81_02_00_02, 1'b0, 1'b0, -1);
        run_frame(8'h7F, 8'h80, 8'h01, 8'hFF, 40'h7F_00_01_00_7F, 40'h7F_80_01_FF_7F, 1'b1, 1'b0, -1);
        run_frame(8'h0A, 8'h0A, 8'h0A, 8'h0A, 40'h0A_0A_0A_0A_0A, 40'h0A_0A_0A_0A_0A, 1'b0, 1'b1, -1);
        run_frame(8'h80, 8'hFF, 8'hFE, 8'h81, 40'h00_00_00_00_00, 40'h80_FF_FE_81_FF, 1'b0, 1'b0, -1);
        run_frame(8'h01, 8'h02, 8'h03, 8'h04, 40'h01_02_03_04_04, 40'h01_02_03_04_04, 1'b0, 1'b0, 2);
        check_zero("after_abort");
        run_frame(8'h11, 8'h22, 8'h33, 8'h44, 40'h11_22_33_44_44, 40'h11_22_33_44_44, 1'b0, 1'b0, -1);

        repeat (3) @(posedge clk_in);
        #1;
        check("queue_a_drained", q_a.size() == 0, 64'(q_a.size()), 64'd0);
        check("queue_b_drained", q_b.size() == 0, 64'(q_b.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
